// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- decode-side handshake of the instruction fetch queue.
//   out_valid : head entry valid (driven by fetch)
//   out_ready : decode accepts the head entry (driven by decode)
//   out_instr : head instruction word
//   out_pc    : word PC of the head instruction
// modport master is the fetch side, modport slave is the decode side.
interface fetch_queue_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (output out_valid, output out_instr, output out_pc, input out_ready);
    modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch stage with a small PC/instruction FIFO.
// Owns the word-addressed fetch PC, drives the combinational instruction
// memory address and buffers {pc, instr} pairs for decode.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   fetch_en     : permits a new fetch this cycle
//   imem_addr    : fetch_pc[ADDR_WIDTH-1:0]
//   imem_data    : instruction at imem_addr (combinational)
//   out_if       : decode handshake (valid/ready, head instr and pc)
//   redirect     : flush the FIFO and load redirect_pc
//   redirect_pc  : new word PC
//   count        : FIFO occupancy, 0..DEPTH
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    input  logic [31:0]              imem_data,
    fetch_queue_if.master            out_if,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop;
    logic          push;
    logic          valid;

    assign imem_addr = fetch_pc[ADDR_WIDTH-1:0];

    always_comb begin
        valid            = (count != '0);
        pop              = valid & out_if.out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push             = fetch_en & ~redirect & ((count != DEPTH_C) | pop);
        out_if.out_valid = valid;
        out_if.out_instr = valid ? instr_mem[rd_ptr] : '0;
        out_if.out_pc    = valid ? pc_mem[rd_ptr]    : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pc_mem    <= '{default: '0};
            instr_mem <= '{default: '0};
        end else if (redirect) begin
            // Flush wins over any handshake or fetch in the same cycle.
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= fetch_pc;
                instr_mem[wr_ptr] <= imem_data;
                wr_ptr            <= wr_ptr + 1'b1;
                fetch_pc          <= fetch_pc + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch stage that sits directly upstream of the decode/control path. It owns the word-addressed fetch PC and drives the combinational instruction memory address. Fetched instructions and their PCs are buffered in a small FIFO, which feeds decode through a valid/ready handshake. Branch and jump resolution redirect the fetch PC and flush the FIFO.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
ADDR_WIDTH, 6, instruction memory word-address width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
fetch_en  input  1  permits a new fetch this cycle
imem_addr  output  ADDR_WIDTH  equals fetch_pc[ADDR_WIDTH-1:0]
imem_data  input  32  instruction at imem_addr, combinational, same cycle
out_valid  output  1  head entry valid
out_ready  input  1  decode accepts head entry
out_instr  output  32  head instruction
out_pc  output  32  word PC of head instruction
redirect  input  1  flush the FIFO and load a new PC
redirect_pc  input  32  new word PC; for branches, the caller supplies PC+1+offset
count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Registered state:
  - fetch_pc (32b)
  - FIFO storage of DEPTH entries, each {pc[31:0], instr[31:0]}
  - read pointer, write pointer and count.
- Reset (reset=1 at an edge) clears all state. Next-cycle outputs: out_valid=0, out_instr=0, out_pc=0, count=0, imem_addr=0. Reset overrides redirect, fetch_en and the handshake. The same applies when reset asserts mid-stream.
- pop = out_valid & out_ready.
- push = fetch_en & !redirect & (count<DEPTH | pop).
- Push writes {fetch_pc, imem_data} at the write pointer, then fetch_pc <= fetch_pc+1.
  - fetch_pc wraps from 0xFFFFFFFF to 0.
  - imem_addr wraps with its low ADDR_WIDTH bits.
- Pop advances the read pointer. Both pointers wrap modulo DEPTH.
- Push and pop in the same cycle are allowed, including when full. count is unchanged and ordering is preserved.
- out_valid = (count!=0).
  - out_instr and out_pc show the head entry when valid and are forced to 0 when empty.
  - There is no fall-through: an instruction pushed at edge N is first visible after edge N.
- Latency: fetch to out_valid is 1 cycle. With out_ready=1 and fetch_en=1, throughput is 1 instruction per cycle with no bubbles.
- Redirect has priority over push and pop:
  - pointers and count go to 0 and fetch_pc <= redirect_pc at that edge.
  - No push occurs that cycle.
  - A handshake in the redirect cycle is treated as consumed by decode but has no further effect, because the flush applies regardless.
  - The next cycle has out_valid=0 and imem_addr=redirect_pc[ADDR_WIDTH-1:0]. The first new instruction is valid one cycle after that.
- Full: count==DEPTH and no pop means no push, and fetch_pc holds.
- Empty: count==0 and out_ready is ignored.
- fetch_en=0: no push and fetch_pc holds. The FIFO continues to drain through pops.
- count never exceeds DEPTH and never underflows. Pointer logic requires no X-propagation from empty entries.

Test Plan:
1. imem mem[0]=0x00084020, mem[1]=0x00094820, mem[2]=0xad090000. Reset for 2 cycles, then fetch_en=1, out_ready=1 -> first cycle after reset out_valid=0, imem_addr=0. Next cycles show out_pc=0/1/2 with out_instr 0x00084020/0x00094820/0xad090000, one per cycle. count stays 1.
2. out_ready=0 for 8 cycles with fetch_en=1 -> count goes 1,2,3,4 and then holds at 4. imem_addr holds at 4 and out_pc stays 0. Then set out_ready=1 -> out_pc 0,1,2,3,4,5 consecutive with no gap, and count stays 4 while pushes and pops overlap.
3. With count=3, pulse redirect=1, redirect_pc=14 -> next cycle count=0, out_valid=0, imem_addr=14. The following cycle out_valid=1, out_pc=14, out_instr=mem[14]=0x016c682a.
4. With count=2, assert fetch_en=0 and out_ready=1 -> two pops at out_pc 0 and 1, then out_valid=0 and out_instr=0. fetch_pc/imem_addr stays at 2 throughout.
5. Assert reset mid-stream with count=3 and redirect=1 in the same cycle -> next cycle count=0, out_valid=0, out_pc=0, imem_addr=0, so reset wins over redirect.
6. Redirect with redirect_pc=0xFFFFFFFF, ADDR_WIDTH=6 -> imem_addr is 63 and then 0. Entries appear with out_pc=0xFFFFFFFF and then 0x00000000, carrying mem[63] and mem[0].
